// File: rtl/shared_reg_rr_arbiter_pkg.sv
// Shared types, default parameters and helpers for the round-robin shared-register arbiter.
// Optional feature: define ARB_LOCK_EN to enable multi-write tenures via the lock inputs.
package shared_reg_rr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    localparam int DEF_NREQ     = 4;
    localparam int DEF_WIDTH    = 8;
    localparam int DEF_MAX_LOCK = 3;

    // Increment an index with wrap-around at n.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/shared_reg_rr_arbiter_if.sv
// Requester-side bus of the shared-register arbiter; lock exists only when ARB_LOCK_EN is defined.
interface shared_reg_rr_arbiter_if
    import shared_reg_rr_arbiter_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH
);
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] wdata;
`ifdef ARB_LOCK_EN
    logic [NREQ-1:0]       lock;
`endif
    logic [NREQ-1:0]       gnt;
    logic [IW-1:0]         owner;
    logic [WIDTH-1:0]      q;
    logic                  wr_done;
    logic                  busy;

`ifdef ARB_LOCK_EN
    modport master (output req, wdata, lock, input gnt, owner, q, wr_done, busy);
    modport slave  (input req, wdata, lock, output gnt, owner, q, wr_done, busy);
`else
    modport master (output req, wdata, input gnt, owner, q, wr_done, busy);
    modport slave  (input req, wdata, output gnt, owner, q, wr_done, busy);
`endif

endinterface

// File: rtl/shared_reg_rr_arbiter_pick.sv
// Combinational round-robin picker: first set request scanning from ptr upward with wrap.
module rr_priority_pick
    import shared_reg_rr_arbiter_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_onehot,
    output logic [IW-1:0]   o_index,
    output logic            o_any
);

    int          w_idx;
    logic [IW-1:0] w_sel;

    // NOTE: every output gets a default before the scan so no path leaves a latch.
    always_comb begin
        o_onehot = '0;
        o_index  = '0;
        o_any    = 1'b0;
        w_idx    = 0;
        w_sel    = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_idx = int'(i_ptr) + i;
            if (w_idx >= NREQ) w_idx = w_idx - NREQ;
            w_sel = IW'(w_idx);
            if (!o_any && i_req[w_sel]) begin
                o_any           = 1'b1;
                o_index         = w_sel;
                o_onehot[w_sel] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shared_reg_rr_arbiter.sv
// Round-robin arbiter and write sequencer for one shared WIDTH-bit register.
// Define ARB_LOCK_EN to let an owner hold its tenure for up to MAX_LOCK back-to-back writes.
module shared_reg_rr_arbiter
    import shared_reg_rr_arbiter_pkg::*;
#(
    parameter int NREQ     = DEF_NREQ,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int MAX_LOCK = DEF_MAX_LOCK
) (
    input  logic                    clk,
    input  logic                    reset,
    shared_reg_rr_arbiter_if.slave  bus
);
    localparam int IW  = $clog2(NREQ);
    localparam int LCW = $clog2(MAX_LOCK + 1);

    state_e           r_state, w_state_nxt;
    logic [IW-1:0]    r_ptr, w_ptr_nxt;
    logic [IW-1:0]    r_owner, w_owner_nxt;
    logic [NREQ-1:0]  r_gnt, w_gnt_nxt;
    logic [WIDTH-1:0] r_q, w_q_nxt;
    logic             r_wr_done, w_wr_done_nxt;
    logic [LCW-1:0]   r_lock_cnt, w_lock_cnt_nxt;
    logic             w_hold;

    logic [NREQ-1:0]  w_pick_onehot;
    logic [IW-1:0]    w_pick_index;
    logic             w_pick_any;

    rr_priority_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .i_req    (bus.req),
        .i_ptr    (r_ptr),
        .o_onehot (w_pick_onehot),
        .o_index  (w_pick_index),
        .o_any    (w_pick_any)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_owner_nxt    = r_owner;
        w_gnt_nxt      = r_gnt;
        w_q_nxt        = r_q;
        w_wr_done_nxt  = 1'b0;
        w_lock_cnt_nxt = r_lock_cnt;
        w_hold         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_gnt_nxt = '0;
                if (w_pick_any) begin
                    w_gnt_nxt      = w_pick_onehot;
                    w_owner_nxt    = w_pick_index;
                    w_lock_cnt_nxt = '0;
                    w_state_nxt    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (bus.req[r_owner]) begin
                    w_q_nxt       = bus.wdata[int'(r_owner)*WIDTH +: WIDTH];
                    w_wr_done_nxt = 1'b1;
`ifdef ARB_LOCK_EN
                    w_hold = bus.lock[r_owner] && (r_lock_cnt < LCW'(MAX_LOCK - 1));
`endif
                    if (w_hold) begin
                        w_lock_cnt_nxt = r_lock_cnt + LCW'(1);
                    end else begin
                        w_ptr_nxt   = IW'(wrap_inc(int'(r_owner), NREQ));
                        w_gnt_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    // Withdrawn request: tenure ends without a write, ptr keeps its place.
                    w_gnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_owner    <= '0;
            r_gnt      <= '0;
            r_q        <= '0;
            r_wr_done  <= 1'b0;
            r_lock_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_owner    <= w_owner_nxt;
            r_gnt      <= w_gnt_nxt;
            r_q        <= w_q_nxt;
            r_wr_done  <= w_wr_done_nxt;
            r_lock_cnt <= w_lock_cnt_nxt;
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.owner   = r_owner;
    assign bus.q       = r_q;
    assign bus.wr_done = r_wr_done;
    assign bus.busy    = (r_state == ST_GRANT);

endmodule

// File: tb/tb_shared_reg_rr_arbiter.sv
// Directed bench for shared_reg_rr_arbiter; expected register writes go through a scoreboard queue.
module tb_shared_reg_rr_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_mis = 0;
    logic [WIDTH-1:0] sb[$];

    shared_reg_rr_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    shared_reg_rr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_LOCK(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write edge: wr_done must be high and q must equal the oldest expected value.
    task automatic check_write(input string tag);
        check({tag, "_wr_done"}, 32'(bus.wr_done), 32'd1);
        n_vec++;
        if (sb.size() == 0) begin
            n_mis++;
            $error("FAIL %s: observed write q=%0h expected no write", tag, bus.q);
        end else begin
            logic [WIDTH-1:0] exp_q;
            exp_q = sb.pop_front();
            n_vec--;
            check({tag, "_q"}, 32'(bus.q), 32'(exp_q));
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slice(input int i, input logic [WIDTH-1:0] v);
        bus.wdata[i*WIDTH +: WIDTH] = v;
    endtask

    initial begin
        logic [NREQ-1:0] exp_gnt;
        bus.req   = 4'b1111;
        bus.wdata = '0;
`ifdef ARB_LOCK_EN
        bus.lock  = '0;
`endif
        for (int i = 0; i < NREQ; i++) set_slice(i, 8'h10 + 8'(i));

        // Reset state, checked while reset is still asserted.
        #20;
        check("rst_gnt", 32'(bus.gnt), 32'd0);
        check("rst_q", 32'(bus.q), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_wr_done", 32'(bus.wr_done), 32'd0);
        #8 reset = 1'b0;
        step();
        check("first_gnt", 32'(bus.gnt), 32'b0001);
        check("first_owner", 32'(bus.owner), 32'd0);
        check("first_busy", 32'(bus.busy), 32'd1);
        sb.push_back(8'h10);
        bus.req = 4'b0001;
        step();
        check_write("first_write");
        check("first_gnt_clr", 32'(bus.gnt), 32'd0);
        bus.req = 4'b0000;

        // Single requester 2.
        set_slice(2, 8'hA5);
        bus.req = 4'b0100;
        step();
        check("single_gnt", 32'(bus.gnt), 32'b0100);
        check("single_owner", 32'(bus.owner), 32'd2);
        sb.push_back(8'hA5);
        step();
        check_write("single_write");
        check("single_gnt_clr", 32'(bus.gnt), 32'd0);
        bus.req = 4'b0000;
        step();
        check("single_wr_done_clr", 32'(bus.wr_done), 32'd0);
        check("single_q_hold", 32'(bus.q), 32'hA5);

        // Reset brings ptr back to 0 for the rotation test.
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_q", 32'(bus.q), 32'd0);
        reset = 1'b0;

        // All four requesting: rotation 0,1,2,3,0 with one write every two cycles.
        for (int i = 0; i < NREQ; i++) set_slice(i, 8'h10 + 8'(i));
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            int o;
            o = k % NREQ;
            exp_gnt = '0;
            exp_gnt[o] = 1'b1;
            step();
            check($sformatf("rr%0d_gnt", k), 32'(bus.gnt), 32'(exp_gnt));
            check($sformatf("rr%0d_owner", k), 32'(bus.owner), 32'(o));
            sb.push_back(8'h10 + 8'(o));
            step();
            check_write($sformatf("rr%0d", k));
            check($sformatf("rr%0d_gnt_clr", k), 32'(bus.gnt), 32'd0);
        end
        bus.req = 4'b0000;
        step();

        // Withdraw before the write edge: no write, ptr stays on requester 1.
        bus.req = 4'b0010;
        step();
        check("wd_gnt", 32'(bus.gnt), 32'b0010);
        bus.req = 4'b0000;
        step();
        check("wd_wr_done", 32'(bus.wr_done), 32'd0);
        check("wd_q", 32'(bus.q), 32'h10);
        check("wd_busy", 32'(bus.busy), 32'd0);
        bus.req = 4'b1010;
        step();
        check("wd_regnt", 32'(bus.gnt), 32'b0010);
        sb.push_back(8'h11);
        step();
        check_write("wd_rewrite");
        bus.req = 4'b0000;

        // Reset 2ns after a grant to requester 3 aborts the tenure.
        set_slice(3, 8'h5C);
        bus.req = 4'b1000;
        step();
        check("abort_gnt", 32'(bus.gnt), 32'b1000);
        #1 reset = 1'b1;
        #1;
        check("abort_gnt_clr", 32'(bus.gnt), 32'd0);
        check("abort_q", 32'(bus.q), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        step();
        check("abort_no_write", 32'(bus.q), 32'd0);
        @(negedge clk);
        bus.req = 4'b0000;
        reset = 1'b0;
        step();
        check("abort_wr_done", 32'(bus.wr_done), 32'd0);

`ifdef ARB_LOCK_EN
        // Locked tenure: three back-to-back writes by requester 0, then forced release.
        bus.req  = 4'b0011;
        bus.lock = 4'b0001;
        set_slice(1, 8'h22);
        step();
        check("lock_gnt", 32'(bus.gnt), 32'b0001);
        set_slice(0, 8'h21);
        sb.push_back(8'h21);
        step();
        check_write("lock_w1");
        check("lock_w1_gnt", 32'(bus.gnt), 32'b0001);
        set_slice(0, 8'h31);
        sb.push_back(8'h31);
        step();
        check_write("lock_w2");
        check("lock_w2_gnt", 32'(bus.gnt), 32'b0001);
        set_slice(0, 8'h41);
        sb.push_back(8'h41);
        step();
        check_write("lock_w3");
        check("lock_release", 32'(bus.gnt), 32'd0);
        bus.lock = 4'b0000;
        step();
        check("lock_next_gnt", 32'(bus.gnt), 32'b0010);
        sb.push_back(8'h22);
        step();
        check_write("lock_next_write");
        bus.req = 4'b0000;
        step();
`endif

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
